// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: supported funct codes,
// instruction field positions and the issue FSM state encoding.
`timescale 1ns/1ps
package alu_pkg;

    // Supported R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // Instruction field slices
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int SH_HI = 10;
    localparam int SH_LO = 6;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    // True when the word is an R-type instruction with a funct the ALU handles
    function automatic logic is_supported(input logic [31:0] instr);
        logic [5:0] fn;
        fn = instr[FN_HI:FN_LO];
        return (instr[OP_HI:OP_LO] == 6'h00) &&
               ((fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_ADD) ||
                (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR));
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue unit: two asynchronous operand read ports,
// one asynchronous debug read port, one synchronous write port.
// Register 0 always reads 0 and never accepts writes; reset clears everything.
`timescale 1ns/1ps
module alu_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rt_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [NUM_REGS];
    logic [31:0] mem_d [NUM_REGS];

    // Read ports: address 0 and out-of-range addresses return 0
    always_comb begin
        rs_data  = '0;
        rt_data  = '0;
        dbg_data = '0;
        if (rs_addr != 5'd0 && int'(rs_addr) < NUM_REGS) rs_data = mem_q[rs_addr];
        if (rt_addr != 5'd0 && int'(rt_addr) < NUM_REGS) rt_data = mem_q[rt_addr];
        if (dbg_addr != 5'd0 && int'(dbg_addr) < NUM_REGS) dbg_data = mem_q[dbg_addr];
    end

    // Next contents: single write, register 0 protected
    always_comb begin
        mem_d = mem_q;
        if (we && waddr != 5'd0 && int'(waddr) < NUM_REGS) mem_d[waddr] = wdata;
    end

    // Storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the shared combinational ALU. Accepts one R-type
// instruction at a time, reads operands, waits ALU_LAT cycles for the ALU,
// then writes the result back to rd.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; the source may hold or change in_instr
// freely while in_ready is low, nothing is sampled then.
`timescale 1ns/1ps
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int ALU_LAT  = 1,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [5:0]  alu_funct,
    input  logic [31:0] alu_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    state_e        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   alu_a_q, alu_a_d;
    logic [31:0]   alu_b_q, alu_b_d;
    logic [4:0]    alu_shamt_q, alu_shamt_d;
    logic [5:0]    alu_funct_q, alu_funct_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;

    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic          rf_we;

    // Write-back happens on the edge that ends WB, so dbg_data shows the old
    // value during WB and the new one afterwards.
    assign rf_we = (state_q == ST_WB);

    alu_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (instr_q[RS_HI:RS_LO]),
        .rs_data  (rs_data),
        .rt_addr  (instr_q[RT_HI:RT_LO]),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (instr_q[RD_HI:RD_LO]),
        .wdata    (result_q)
    );

    // Next-state and datapath update for the issue FSM
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_shamt_d = alu_shamt_q;
        alu_funct_d = alu_funct_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_supported(in_instr)) begin
                        instr_d = in_instr;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // Previous write-back has already committed, so no forwarding
                alu_a_d     = rs_data;
                alu_b_d     = rt_data;
                alu_shamt_d = instr_q[SH_HI:SH_LO];
                alu_funct_d = instr_q[FN_HI:FN_LO];
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    result_d = alu_out;
                    state_d  = ST_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_shamt_q <= '0;
            alu_funct_q <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_shamt_q <= alu_shamt_d;
            alu_funct_q <= alu_funct_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_shamt = alu_shamt_q;
    assign alu_funct = alu_funct_q;
    assign wb_valid  = (state_q == ST_WB);
    assign wb_rd     = instr_q[RD_HI:RD_LO];
    assign wb_data   = result_q;
    assign err       = err_q;

endmodule
